// File: rtl/button_event_encoder.sv
// Encodes debounced button transitions into PRESS / RELEASE / LONG events queued in a fall-through FIFO.
// Long-press detection (hold counter, LONG event, HELD state) is built only when BTN_EVT_LONG_EN is defined.
module button_event_encoder #(
    parameter int              CNT_W      = 24,
    parameter logic [CNT_W-1:0] LONG_TICKS = 24'd5000000,
    parameter int              FIFO_DEPTH = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_state,
    output logic                          o_evt_valid,
    output logic [1:0]                    o_evt_code,
    input  logic                          i_evt_ready,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
    output logic                          o_overflow,
    input  logic                          i_overflow_clr
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [1:0] EVT_PRESS   = 2'b01;
    localparam logic [1:0] EVT_RELEASE = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_HELD    = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic       push;
    logic [1:0] push_code;

`ifdef BTN_EVT_LONG_EN
    localparam logic [1:0]       EVT_LONG  = 2'b11;
    localparam logic [CNT_W-1:0] LONG_LAST = LONG_TICKS - CNT_W'(1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^LONG_TICKS;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // At most one event per cycle; a release always wins over LONG on the same edge.
    always_comb begin
        state_d   = state_q;
        push      = 1'b0;
        push_code = 2'b00;
`ifdef BTN_EVT_LONG_EN
        cnt_d     = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (i_state) begin
                    push      = 1'b1;
                    push_code = EVT_PRESS;
                    state_d   = ST_PRESSED;
`ifdef BTN_EVT_LONG_EN
                    cnt_d     = '0;
`endif
                end
            end
            ST_PRESSED: begin
                if (!i_state) begin
                    push      = 1'b1;
                    push_code = EVT_RELEASE;
                    state_d   = ST_IDLE;
                end
`ifdef BTN_EVT_LONG_EN
                else if (cnt_q == LONG_LAST) begin
                    push      = 1'b1;
                    push_code = EVT_LONG;
                    state_d   = ST_HELD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            ST_HELD: begin
                if (!i_state) begin
                    push      = 1'b1;
                    push_code = EVT_RELEASE;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    logic [1:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;
    logic          pop, full, do_push, drop;

    assign pop     = (count != '0) && i_evt_ready;
    assign full    = (count == CW'(FIFO_DEPTH));
    // A pop frees the slot on the same edge, so a full FIFO can still accept.
    assign do_push = push && (!full || pop);
    assign drop    = push && full && !pop;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !pop)      count <= count + CW'(1);
            else if (!do_push && pop) count <= count - CW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_push) mem[wr_ptr] <= push_code;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_overflow <= 1'b0;
        end else if (drop) begin
            o_overflow <= 1'b1;
        end else if (i_overflow_clr) begin
            o_overflow <= 1'b0;
        end
    end

    assign o_evt_valid  = (count != '0);
    assign o_evt_code   = o_evt_valid ? mem[rd_ptr] : 2'b00;
    assign o_fifo_count = count;

endmodule

// File: tb/tb_button_event_encoder.sv
// Directed bench for button_event_encoder with LONG_TICKS = 8 and FIFO_DEPTH = 4.
// Expectations follow the BTN_EVT_LONG_EN build setting (LONG events only when it is defined).
module tb_button_event_encoder;

    localparam int CNT_W      = 24;
    localparam int FIFO_DEPTH = 4;
`ifdef BTN_EVT_LONG_EN
    localparam bit LONG_EN = 1'b1;
`else
    localparam bit LONG_EN = 1'b0;
`endif

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_state;
    logic       i_evt_ready;
    logic       i_overflow_clr;
    logic       o_evt_valid;
    logic [1:0] o_evt_code;
    logic [2:0] o_fifo_count;
    logic       o_overflow;

    int n_checks = 0;
    int n_errors = 0;
    logic [1:0] exp_q[$];

    button_event_encoder #(
        .CNT_W      (CNT_W),
        .LONG_TICKS (24'd8),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_state        (i_state),
        .o_evt_valid    (o_evt_valid),
        .o_evt_code     (o_evt_code),
        .i_evt_ready    (i_evt_ready),
        .o_fifo_count   (o_fifo_count),
        .o_overflow     (o_overflow),
        .i_overflow_clr (i_overflow_clr)
    );

    // clock / reset
    always #5 i_clk = ~i_clk;

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic press_release();
        i_state = 1'b1;
        step();
        i_state = 1'b0;
        step();
    endtask

    // Pops every queued event against the scoreboard, then confirms an empty pop is ignored.
    task automatic drain_check(input string tag);
        logic [1:0] e;
        check({tag, "_count"}, 32'(o_fifo_count), 32'(exp_q.size()));
        i_evt_ready = 1'b1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, "_valid"}, 32'(o_evt_valid), 32'd1);
            check({tag, "_code"}, 32'(o_evt_code), 32'(e));
            step();
        end
        step();
        check({tag, "_empty_valid"}, 32'(o_evt_valid), 32'd0);
        check({tag, "_empty_count"}, 32'(o_fifo_count), 32'd0);
        i_evt_ready = 1'b0;
    endtask

    initial begin
        i_rst          = 1'b1;
        i_state        = 1'b0;
        i_evt_ready    = 1'b0;
        i_overflow_clr = 1'b0;
        step();
        step();
        check("rst_valid", 32'(o_evt_valid), 32'd0);
        check("rst_count", 32'(o_fifo_count), 32'd0);
        check("rst_code", 32'(o_evt_code), 32'd0);
        check("rst_ovf", 32'(o_overflow), 32'd0);
        i_rst = 1'b0;

        // short press, consumer always ready
        i_state     = 1'b1;
        i_evt_ready = 1'b1;
        step();
        check("short_press_valid", 32'(o_evt_valid), 32'd1);
        check("short_press_code", 32'(o_evt_code), 32'h1);
        check("short_press_count", 32'(o_fifo_count), 32'd1);
        step();
        check("short_popped", 32'(o_fifo_count), 32'd0);
        step();
        i_state = 1'b0;
        step();
        check("short_rel_valid", 32'(o_evt_valid), 32'd1);
        check("short_rel_code", 32'(o_evt_code), 32'h2);
        step();
        check("short_end_count", 32'(o_fifo_count), 32'd0);
        i_evt_ready = 1'b0;

        // long press held 20 cycles, consumer stalled
        i_state = 1'b1;
        step();
        check("long_press_count", 32'(o_fifo_count), 32'd1);
        check("long_press_code", 32'(o_evt_code), 32'h1);
        repeat (7) step();
        check("long_e7_count", 32'(o_fifo_count), 32'd1);
        step();
        check("long_e8_count", 32'(o_fifo_count), LONG_EN ? 32'd2 : 32'd1);
        repeat (11) step();
        i_state = 1'b0;
        step();
        check("long_rel_count", 32'(o_fifo_count), LONG_EN ? 32'd3 : 32'd2);
        exp_q.push_back(2'b01);
        if (LONG_EN) exp_q.push_back(2'b11);
        exp_q.push_back(2'b10);
        drain_check("long");

        // release sampled at exactly E+8 beats LONG
        i_state = 1'b1;
        step();
        repeat (7) step();
        i_state = 1'b0;
        step();
        check("bound_count", 32'(o_fifo_count), 32'd2);
        exp_q.push_back(2'b01);
        exp_q.push_back(2'b10);
        drain_check("bound");

        // overflow: six events into four slots
        repeat (2) press_release();
        check("ovf_full_count", 32'(o_fifo_count), 32'd4);
        check("ovf_full_flag", 32'(o_overflow), 32'd0);
        press_release();
        check("ovf_sat_count", 32'(o_fifo_count), 32'd4);
        check("ovf_set", 32'(o_overflow), 32'd1);
        i_state        = 1'b1;
        i_overflow_clr = 1'b1;
        step();
        i_overflow_clr = 1'b0;
        check("ovf_drop_beats_clr", 32'(o_overflow), 32'd1);
        i_state = 1'b0;
        step();
        check("ovf_still_set", 32'(o_overflow), 32'd1);
        i_overflow_clr = 1'b1;
        step();
        i_overflow_clr = 1'b0;
        check("ovf_cleared", 32'(o_overflow), 32'd0);
        exp_q.push_back(2'b01);
        exp_q.push_back(2'b10);
        exp_q.push_back(2'b01);
        exp_q.push_back(2'b10);
        drain_check("ovf");

        // full FIFO with push and pop on the same edge
        repeat (2) press_release();
        check("pp_full_count", 32'(o_fifo_count), 32'd4);
        i_state     = 1'b1;
        i_evt_ready = 1'b1;
        step();
        check("pp_a_count", 32'(o_fifo_count), 32'd4);
        check("pp_a_ovf", 32'(o_overflow), 32'd0);
        check("pp_a_head", 32'(o_evt_code), 32'h2);
        i_state = 1'b0;
        step();
        i_evt_ready = 1'b0;
        check("pp_b_count", 32'(o_fifo_count), 32'd4);
        check("pp_b_ovf", 32'(o_overflow), 32'd0);
        check("pp_b_head", 32'(o_evt_code), 32'h1);
        exp_q.push_back(2'b01);
        exp_q.push_back(2'b10);
        exp_q.push_back(2'b01);
        exp_q.push_back(2'b10);
        drain_check("pp");

        // reset in the middle of a hold
        i_state = 1'b1;
        step();
        repeat (4) step();
        check("mid_pre_count", 32'(o_fifo_count), 32'd1);
        i_rst = 1'b1;
        step();
        check("mid_rst_valid", 32'(o_evt_valid), 32'd0);
        check("mid_rst_count", 32'(o_fifo_count), 32'd0);
        check("mid_rst_code", 32'(o_evt_code), 32'd0);
        check("mid_rst_ovf", 32'(o_overflow), 32'd0);
        i_rst = 1'b0;
        step();
        check("mid_press_count", 32'(o_fifo_count), 32'd1);
        check("mid_press_code", 32'(o_evt_code), 32'h1);
        repeat (7) step();
        check("mid_e7_count", 32'(o_fifo_count), 32'd1);
        step();
        check("mid_e8_count", 32'(o_fifo_count), LONG_EN ? 32'd2 : 32'd1);
        i_state = 1'b0;
        step();
        check("mid_rel_count", 32'(o_fifo_count), LONG_EN ? 32'd3 : 32'd2);
        exp_q.push_back(2'b01);
        if (LONG_EN) exp_q.push_back(2'b11);
        exp_q.push_back(2'b10);
        drain_check("mid");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
